rr_handshake_arbiter: RTL and testbench
=======================================

Name: rr_handshake_arbiter

Overview:
- Shares one upstream req/ack data source (a producer or an async_operator output) among num_req downstream requesters that use the same req/ack protocol.
- Grants requesters round-robin and issues one upstream request per grant.
- Delivers the captured word and a one-cycle ack pulse only to the granted requester.
- Also provides a sticky upstream-stall watchdog and a transfer counter for throughput benches.

Parameters:
- num_req, 4, number of downstream requesters (2..16).
- idx_width, 2, width of grant index; must satisfy 2**idx_width >= num_req.
- data_width, 32, data word width.
- timeout, 1024, cycles in REQ without up_ack before timeout_err sets; 0 disables the watchdog.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset, asynchronous, active-low.
- req_in  in  num_req  per-requester request; bit i held high until ack_out[i].
- ack_out  out  num_req  per-requester one-cycle ack pulse; dout valid in the same cycle.
- dout  out  data_width  delivered word (registered).
- up_req  out  1  request to shared upstream source.
- up_ack  in  1  upstream one-cycle ack; up_din valid in the same cycle.
- up_din  in  data_width  upstream data.
- grant_idx  out  idx_width  index of the current or last granted requester.
- busy  out  1  high in REQ and DONE.
- timeout_err  out  1  sticky upstream-stall flag.
- xfer_count  out  32  completed transfers, wraps modulo 2^32.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; ack_out=0, dout=0, up_req=0, grant_idx=0, busy=0, timeout_err=0, xfer_count=0, watchdog=0.
  - Internal last-served pointer = num_req-1, so the first grant goes to index 0.
  - Reset release is sampled on clk; the first active edge after release evaluates IDLE.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If req_in has no bit set, stay in IDLE.
  - Otherwise pick the first set bit scanning (last+1) mod num_req upward with wrap.
  - Register grant_idx, set up_req=1, clear watchdog, go to REQ.
- REQ:
  - up_req is held at 1.
  - On up_ack=1: dout<=up_din, ack_out[grant_idx]<=1 (all other bits 0), up_req<=0, last<=grant_idx, xfer_count<=xfer_count+1, go to DONE.
  - Without up_ack: watchdog increments, saturating. When timeout!=0 and watchdog reaches timeout-1, timeout_err<=1. Stay in REQ and keep waiting; there is no abort.
- DONE:
  - ack_out<=0; go to IDLE.
  - Guarantees up_req is low for at least 2 cycles between transactions, which satisfies the upstream req & ~ack rule.
- Latency:
  - up_req rises 1 cycle after req_in is sampled in IDLE.
  - ack_out rises 1 cycle after up_ack.
  - With a zero-stall upstream: one transfer per 4 cycles; 5000 transfers complete in 20000 cycles.
- Withdrawal: if req_in[grant_idx] drops while in REQ, the upstream transaction still completes. ack_out[grant_idx] still pulses and the word is consumed; there is no cancel.
- Requests are level-sensitive. A requester still high after its ack is re-eligible, but only after all other pending requesters have been served (fairness).
- up_ack outside REQ is ignored: no capture, no count, no ack_out.
- dout holds its value between transfers.
- grant_idx keeps its last value in IDLE.
- ack_out is one-hot or zero at all times.
- xfer_count wraps 0xFFFFFFFF -> 0 with no flag.
- Requester bits at index >= num_req do not exist; grant_idx never exceeds num_req-1.

Test Plan:
1. Single requester, zero-stall upstream: req_in=4'b0010 held; upstream counts from 0.
   - Expect ack_out[1] pulses every 4 cycles carrying 0,1,2,...
   - grant_idx=1; xfer_count=N after N pulses.
2. All four requesters held high.
   - Expect grant order 0,1,2,3,0,1...; each ack_out is one-hot.
   - Data sequence 0,1,2,3,4,5... is distributed in that order.
3. Upstream stall: timeout=8, up_ack held low with one request pending.
   - Expect timeout_err rises on the 8th REQ cycle and up_req stays 1.
   - A later up_ack completes the transfer; timeout_err stays 1 until reset.
4. Reset mid-REQ: assert rst=0 asynchronously with up_req=1.
   - Expect up_req, busy and ack_out go 0 immediately, without waiting for a clk edge.
   - After release, with req_in=4'b1111, the first grant is 0.
5. Withdrawal: req_in[2] drops one cycle after its grant while up_ack arrives 3 cycles later.
   - Expect ack_out[2] still pulses with the upstream word and xfer_count increments.
6. num_req=3, idx_width=2, requesters 0 and 2 held high.
   - Expect alternating grants 0,2,0,2 and grant_idx never equals 3.

Source files
------------

// File: rtl/rr_handshake_arbiter_if.sv
// Bundle of the arbiter's downstream requester lines and its upstream
// req/ack source lines.
//
// Signals:
//   req_in      per-requester request, held until the matching ack_out bit
//   ack_out     per-requester one-cycle ack pulse, dout valid with it
//   dout        delivered word
//   up_req      request towards the shared upstream source
//   up_ack      upstream one-cycle ack, up_din valid with it
//   up_din      upstream data word
//   grant_idx   current or most recently granted requester
//   busy        arbiter has a transaction in flight
//   timeout_err sticky upstream-stall flag
//   xfer_count  completed transfers (wraps modulo 2^32)
//
// Modports:
//   master  the arbiter's view (it drives up_req and the downstream acks)
//   slave   the environment's view (requesters plus upstream source)
interface rr_handshake_arbiter_if #(
  parameter int unsigned num_req    = 4,
  parameter int unsigned idx_width  = 2,
  parameter int unsigned data_width = 32
);
  logic [num_req-1:0]    req_in;
  logic [num_req-1:0]    ack_out;
  logic [data_width-1:0] dout;
  logic                  up_req;
  logic                  up_ack;
  logic [data_width-1:0] up_din;
  logic [idx_width-1:0]  grant_idx;
  logic                  busy;
  logic                  timeout_err;
  logic [31:0]           xfer_count;

  modport master (
    input  req_in, up_ack, up_din,
    output ack_out, dout, up_req, grant_idx, busy, timeout_err, xfer_count
  );

  modport slave (
    output req_in, up_ack, up_din,
    input  ack_out, dout, up_req, grant_idx, busy, timeout_err, xfer_count
  );
endinterface

// File: rtl/rr_handshake_arbiter.sv
// Round-robin arbiter sharing one upstream req/ack data source among
// num_req downstream requesters. Each grant issues exactly one upstream
// request; the captured word and a one-cycle ack go only to the grantee.
// A sticky watchdog flags an upstream that stalls too long in REQ, and a
// free-running transfer counter supports throughput measurements.
//
// Ports:
//   clk  clock, all state changes on the rising edge
//   rst  asynchronous active-low reset
//   bus  rr_handshake_arbiter_if.master (requesters, upstream, status)
//
// Parameters:
//   num_req    number of requesters (2..16)
//   idx_width  grant index width, 2**idx_width >= num_req
//   data_width data word width
//   timeout    REQ cycles without up_ack before timeout_err sets; 0 disables
module rr_handshake_arbiter #(
  parameter int unsigned num_req    = 4,
  parameter int unsigned idx_width  = 2,
  parameter int unsigned data_width = 32,
  parameter int unsigned timeout    = 1024
) (
  input logic clk,
  input logic rst,
  rr_handshake_arbiter_if.master bus
);

  // Wide enough to count up to timeout, so the saturated value always
  // sits at or beyond the trip point.
  localparam int unsigned wd_width = (timeout > 1) ? $clog2(timeout + 1) : 1;
  localparam int unsigned wd_limit = (timeout > 0) ? timeout - 1 : 0;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  state_t               state;
  logic [idx_width-1:0] last_served;
  logic [wd_width-1:0]  watchdog;
  logic [wd_width-1:0]  wd_inc;
  logic                 pick_valid;
  logic [idx_width-1:0] pick_idx;

  function automatic logic [idx_width-1:0] rr_index(
    input logic [idx_width-1:0] base,
    input int unsigned          step
  );
    return idx_width'((32'(base) + step) % num_req);
  endfunction

  // Scan starting one past the last served requester and wrapping, so the
  // requester just served is considered last.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 1; k <= num_req; k++) begin
      if (!pick_valid &&
          (|(bus.req_in & (num_req'(1) << rr_index(last_served, k))))) begin
        pick_valid = 1'b1;
        pick_idx   = rr_index(last_served, k);
      end
    end
  end

  always_comb begin
    wd_inc = (watchdog == '1) ? watchdog : watchdog + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      last_served     <= idx_width'(num_req - 1);
      watchdog        <= '0;
      bus.ack_out     <= '0;
      bus.dout        <= '0;
      bus.up_req      <= 1'b0;
      bus.grant_idx   <= '0;
      bus.busy        <= 1'b0;
      bus.timeout_err <= 1'b0;
      bus.xfer_count  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            bus.grant_idx <= pick_idx;
            bus.up_req    <= 1'b1;
            bus.busy      <= 1'b1;
            watchdog      <= '0;
            state         <= REQ;
          end
        end

        REQ: begin
          if (bus.up_ack) begin
            bus.dout       <= bus.up_din;
            bus.ack_out    <= num_req'(1) << bus.grant_idx;
            bus.up_req     <= 1'b0;
            last_served    <= bus.grant_idx;
            bus.xfer_count <= bus.xfer_count + 32'd1;
            state          <= DONE;
          end else begin
            watchdog <= wd_inc;
            // Trips as the count lands on timeout-1, so the flag is visible
            // during the timeout-th consecutive REQ cycle.
            if ((timeout != 0) && (32'(wd_inc) >= wd_limit)) begin
              bus.timeout_err <= 1'b1;
            end
          end
        end

        DONE: begin
          // Together with the following IDLE cycle this keeps up_req low
          // for at least two cycles between upstream transactions.
          bus.ack_out <= '0;
          bus.busy    <= 1'b0;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_handshake_arbiter.sv
module tb_rr_handshake_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic rst3;
  always #5 clk = ~clk;

  rr_handshake_arbiter_if #(.num_req(4), .idx_width(2), .data_width(32)) bus ();
  rr_handshake_arbiter #(
    .num_req(4), .idx_width(2), .data_width(32), .timeout(8)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.master)
  );

  rr_handshake_arbiter_if #(.num_req(3), .idx_width(2), .data_width(32)) bus3 ();
  rr_handshake_arbiter #(
    .num_req(3), .idx_width(2), .data_width(32), .timeout(0)
  ) dut3 (
    .clk(clk), .rst(rst3), .bus(bus3.master)
  );

  typedef struct {
    int unsigned idx;
    logic [31:0] data;
  } exp_t;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  exp_t        sb[$];
  exp_t        sb3[$];
  int unsigned acks_seen = 0;
  int unsigned acks3     = 0;

  // stimulus controls
  int unsigned stall_cycles = 0;
  bit          rand_stall   = 1'b0;
  bit          spurious_en  = 1'b0;
  bit          rand_req     = 1'b0;
  logic [3:0]  req_fixed    = '0;

  // reference model state
  int unsigned pend_grant  = 0;
  int unsigned last_model  = 3;
  logic [3:0]  req_at_edge = '0;
  logic [31:0] next_word   = '0;
  logic [31:0] dout_model  = '0;
  logic [31:0] cnt_model   = '0;
  bit          err_model   = 1'b0;
  bit          prev_up_req = 1'b0;
  int unsigned req_cyc     = 0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Round-robin rule: first set bit after the last served index, wrapping.
  function automatic int unsigned rr_pick(input logic [3:0] mask,
                                          input int unsigned last,
                                          input int unsigned n);
    int unsigned j;
    for (int unsigned s = 1; s <= n; s++) begin
      j = (last + s) % n;
      if (((mask >> j) & 4'd1) != 4'd0) return j;
    end
    return last;
  endfunction

  // Request lines are sampled by the DUT on the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      req_at_edge = bus.req_in;
    end
  end

  // Requester driver: fixed pattern, or independent random requesters that
  // hold until acked and occasionally withdraw.
  initial begin
    bus.req_in = '0;
    forever begin
      @(negedge clk);
      if (rand_req) begin
        for (int i = 0; i < 4; i++) begin
          if (bus.ack_out[i]) begin
            if ($urandom_range(0, 1) == 0) bus.req_in[i] = 1'b0;
          end else if (!bus.req_in[i]) begin
            if ($urandom_range(0, 3) == 0) bus.req_in[i] = 1'b1;
          end else if ($urandom_range(0, 15) == 0) begin
            bus.req_in[i] = 1'b0;
          end
        end
      end else begin
        bus.req_in = req_fixed;
      end
    end
  end

  // Upstream source: registered response (ack one cycle after it first sees
  // up_req) plus stall cycles; each issued word becomes an expected delivery.
  initial begin
    int unsigned seen;
    int unsigned cur_stall;
    exp_t        e;
    seen = 0;
    cur_stall = 0;
    bus.up_ack = 1'b0;
    bus.up_din = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        bus.up_ack = 1'b0;
        seen = 0;
        next_word = '0;
      end else if (bus.up_ack) begin
        bus.up_ack = 1'b0;
      end else if (bus.up_req) begin
        if (seen == 0) cur_stall = rand_stall ? $urandom_range(0, 4) : stall_cycles;
        seen++;
        if (seen >= cur_stall + 2) begin
          bus.up_din = next_word;
          bus.up_ack = 1'b1;
          e.idx  = pend_grant;
          e.data = next_word;
          sb.push_back(e);
          next_word = next_word + 32'd1;
          seen = 0;
        end
      end else if (spurious_en && ($urandom_range(0, 5) == 0)) begin
        bus.up_din = $urandom;
        bus.up_ack = 1'b1;
      end
    end
  end

  // Monitor for the 4-requester instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        sb.delete();
        last_model  = 3;
        prev_up_req = 1'b0;
        err_model   = 1'b0;
        cnt_model   = '0;
        dout_model  = '0;
        req_cyc     = 0;
      end else begin
        if (bus.up_req && !prev_up_req) begin
          pend_grant = rr_pick(req_at_edge, last_model, 4);
          last_model = pend_grant;
          chk("grant_idx", 32'(bus.grant_idx), pend_grant);
        end
        if (bus.ack_out != '0) begin
          acks_seen++;
          if (sb.size() == 0) begin
            chk("unexpected_ack", 32'(bus.ack_out), 32'd0);
          end else begin
            e = sb.pop_front();
            cnt_model  = cnt_model + 32'd1;
            dout_model = e.data;
            chk("ack_out", 32'(bus.ack_out), 32'd1 << e.idx);
            chk("dout", bus.dout, e.data);
            chk("xfer_count", bus.xfer_count, cnt_model);
          end
        end else begin
          chk("dout_hold", bus.dout, dout_model);
        end
        req_cyc = bus.up_req ? req_cyc + 1 : 0;
        if (req_cyc >= 8) err_model = 1'b1;
        chk("timeout_err", 32'(bus.timeout_err), 32'(err_model));
        chk("ack_onehot", 32'($onehot0(bus.ack_out)), 32'd1);
        prev_up_req = bus.up_req;
      end
    end
  end

  // Upstream source and monitor for the 3-requester instance.
  initial begin
    int unsigned seen3;
    logic [31:0] word3;
    seen3 = 0;
    word3 = '0;
    bus3.up_ack = 1'b0;
    bus3.up_din = '0;
    forever begin
      @(negedge clk);
      if (!rst3) begin
        bus3.up_ack = 1'b0;
        seen3 = 0;
      end else if (bus3.up_ack) begin
        bus3.up_ack = 1'b0;
      end else if (bus3.up_req) begin
        seen3++;
        if (seen3 >= 2) begin
          bus3.up_din = word3;
          bus3.up_ack = 1'b1;
          word3 = word3 + 32'd1;
          seen3 = 0;
        end
      end
    end
  end

  initial begin
    exp_t e3;
    forever begin
      @(negedge clk);
      if (rst3) begin
        chk("t6_grant_range", 32'(bus3.grant_idx < 2'd3), 32'd1);
        if (bus3.ack_out != '0) begin
          acks3++;
          if (sb3.size() == 0) begin
            chk("t6_unexpected_ack", 32'(bus3.ack_out), 32'd0);
          end else begin
            e3 = sb3.pop_front();
            chk("t6_ack_out", 32'(bus3.ack_out), 32'd1 << e3.idx);
            chk("t6_dout", bus3.dout, e3.data);
          end
        end
      end
    end
  end

  task automatic wait_acks(input int unsigned n, input string name);
    int unsigned target;
    int unsigned budget;
    target = acks_seen + n;
    budget = 0;
    while (acks_seen < target && budget < 100 * n + 100) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (acks_seen < target) chk(name, acks_seen, target);
  endtask

  task automatic wait_up_req(input string name);
    int unsigned budget;
    budget = 0;
    while (!bus.up_req && budget < 50) begin
      @(negedge clk);
      #1;
      budget++;
    end
    chk(name, 32'(bus.up_req), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int unsigned t0;
    int unsigned b;
    exp_t        e;
    rst  = 1'b0;
    rst3 = 1'b0;
    bus3.req_in = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ack_out", 32'(bus.ack_out), 32'd0);
    chk("rst_dout", bus.dout, 32'd0);
    chk("rst_up_req", 32'(bus.up_req), 32'd0);
    chk("rst_grant_idx", 32'(bus.grant_idx), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
    chk("rst_xfer_count", bus.xfer_count, 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;

    // single requester, zero-stall upstream
    req_fixed = 4'b0010;
    wait_acks(1, "t1_first_ack");
    t0 = cyc;
    wait_acks(10, "t1_run");
    chk("t1_period", cyc - t0, 32'd40);
    chk("t1_grant", 32'(bus.grant_idx), 32'd1);
    chk("t1_count", bus.xfer_count, 32'd11);

    // all requesters held high
    req_fixed = 4'b1111;
    wait_acks(8, "t2_run");

    // withdrawal after grant
    req_fixed = '0;
    repeat (6) @(negedge clk);
    stall_cycles = 3;
    req_fixed = 4'b0100;
    wait_up_req("t5_up_req");
    req_fixed = '0;
    wait_acks(1, "t5_ack");
    chk("t5_grant", 32'(bus.grant_idx), 32'd2);

    // randomized traffic
    stall_cycles = 0;
    rand_stall   = 1'b1;
    spurious_en  = 1'b1;
    rand_req     = 1'b1;
    wait_acks(60, "rand_run");
    rand_req    = 1'b0;
    req_fixed   = '0;
    rand_stall  = 1'b0;
    spurious_en = 1'b0;
    repeat (15) @(negedge clk);
    #1;
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // upstream stall and watchdog
    stall_cycles = 30;
    req_fixed = 4'b0001;
    wait_up_req("t3_up_req");
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk);
      #1;
      if (k == 7) chk("t3_err_early", 32'(bus.timeout_err), 32'd0);
    end
    chk("t3_err_set", 32'(bus.timeout_err), 32'd1);
    chk("t3_up_req_held", 32'(bus.up_req), 32'd1);
    chk("t3_busy", 32'(bus.busy), 32'd1);
    req_fixed = '0;
    wait_acks(1, "t3_ack");
    repeat (5) @(negedge clk);
    #1;
    chk("t3_err_sticky", 32'(bus.timeout_err), 32'd1);

    // asynchronous reset in the middle of REQ
    req_fixed = 4'b1000;
    wait_up_req("t4_up_req");
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("t4_up_req", 32'(bus.up_req), 32'd0);
    chk("t4_busy", 32'(bus.busy), 32'd0);
    chk("t4_ack_out", 32'(bus.ack_out), 32'd0);
    chk("t4_timeout_err", 32'(bus.timeout_err), 32'd0);
    chk("t4_xfer_count", bus.xfer_count, 32'd0);
    chk("t4_grant_idx", 32'(bus.grant_idx), 32'd0);
    req_fixed = 4'b1111;
    stall_cycles = 0;
    @(negedge clk);
    #2 rst = 1'b1;
    wait_up_req("t4_regrant");
    chk("t4_first_grant", 32'(bus.grant_idx), 32'd0);
    wait_acks(4, "t4_run");
    req_fixed = '0;

    // three requesters, 0 and 2 active
    for (int i = 0; i < 6; i++) begin
      e.idx  = (i % 2 == 0) ? 0 : 2;
      e.data = 32'(i);
      sb3.push_back(e);
    end
    @(negedge clk);
    #2;
    rst3 = 1'b1;
    bus3.req_in = 3'b101;
    b = 0;
    while (acks3 < 6 && b < 200) begin
      @(negedge clk);
      #1;
      b++;
    end
    chk("t6_acks", acks3, 32'd6);
    bus3.req_in = '0;

    repeat (10) @(negedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("sb3_drained", 32'(sb3.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
